inst_load_ctrl: RTL
===================

INST_LOAD_CTRL -- requirements
Module: inst_load_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, number of instruction bytes in the memory.
REQ-002 SHALL have parameter ADDR_W, default 5, memory address width (log2 MEM_DEPTH).
REQ-003 SHALL have port clka  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port restart  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port load_start  input  1  one-cycle request to clear and reload the program.
REQ-006 SHALL have port load_len  input  ADDR_W+1  byte count to load (0..MEM_DEPTH), sampled with load_start.
REQ-007 SHALL have port byte_valid  input  1  the loader byte stream holds a byte.
REQ-008 SHALL have port byte_data  input  8  the loader byte.
REQ-009 SHALL have port byte_ready  output  1  the controller accepts the byte this cycle.
REQ-010 SHALL have port mem_we  output  1  memory write strobe.
REQ-011 SHALL have port mem_waddr  output  ADDR_W  memory write address.
REQ-012 SHALL have port mem_wdata  output  8  memory write data.
REQ-013 SHALL have port mem_raddr  output  ADDR_W  memory read address; read is synchronous with 1-cycle latency.
REQ-014 SHALL have port mem_rdata  input  8  memory read data.
REQ-015 SHALL have port fetch_req  input  1  CPU fetch request.
REQ-016 SHALL have port fetch_pc  input  8  CPU program counter.
REQ-017 SHALL have port fetch_ack  output  1  one-cycle pulse marking fetch_inst valid.
REQ-018 SHALL have port fetch_inst  output  8  the fetched instruction byte.
REQ-019 SHALL have port pc_fault  output  1  one-cycle pulse for an out-of-range fetch.
REQ-020 SHALL have port cpu_run  output  1  the program is loaded and the CPU may fetch.
REQ-021 SHALL have port load_busy  output  1  a clear or load is in progress.

Function
REQ-022 SHALL implement states IDLE, CLEAR, LOAD and RUN.
REQ-023 In IDLE or RUN, load_start SHALL latch load_len, zero the address counter and enter CLEAR next cycle.
REQ-024 load_start SHALL override fetch_req in the same cycle; that fetch is dropped with no ack.
REQ-025 CLEAR SHALL assert mem_we with mem_wdata=0x00 at addresses 0..MEM_DEPTH-1, one per cycle, over exactly MEM_DEPTH cycles.
REQ-026 After the last clear write, the controller SHALL enter LOAD, or RUN directly when the latched length is 0.
REQ-027 LOAD SHALL assert byte_ready.
REQ-028 Each cycle with byte_valid=1 in LOAD SHALL write byte_data to mem_waddr=counter and increment the counter.
REQ-029 LOAD SHALL enter RUN the cycle after the byte whose count equals the latched length is accepted.
REQ-030 A load_len greater than MEM_DEPTH SHALL be clamped to MEM_DEPTH.
REQ-031 load_start SHALL be ignored in CLEAR and LOAD.
REQ-032 byte_ready SHALL be 0 outside LOAD.
REQ-033 cpu_run SHALL be 1 only in RUN.
REQ-034 load_busy SHALL be 1 only in CLEAR or LOAD.
REQ-035 In RUN, fetch_req=1 with fetch_pc[7:ADDR_W]=0 SHALL drive mem_raddr=fetch_pc[ADDR_W-1:0].
REQ-036 For such a fetch, the next cycle SHALL give fetch_ack=1 and fetch_inst=mem_rdata.
REQ-037 RUN SHALL accept back-to-back fetches at one per cycle.
REQ-038 A RUN fetch with any bit of fetch_pc[7:ADDR_W] set SHALL give, the next cycle, fetch_ack=1, fetch_inst=0x00 and pc_fault=1, with no wrap-around.
REQ-039 fetch_req outside RUN SHALL be ignored, with no ack.
REQ-040 A fetch accepted in the cycle before load_start SHALL still be acked.
REQ-041 fetch_inst SHALL hold its last value when fetch_ack=0.
REQ-042 mem_we SHALL be 0 in IDLE and RUN.

Reset
REQ-043 restart SHALL asynchronously force state IDLE, counter 0 and latched length 0.
REQ-044 restart SHALL asynchronously force all outputs to 0, including fetch_inst=0x00.
REQ-045 restart mid-CLEAR or mid-LOAD SHALL abandon the operation; memory contents are then undefined until the next load.

Structure
REQ-046 The state encoding, MEM_DEPTH default and FAULT_INST (0x00) SHALL live in a shared package, inst_pkg.
REQ-047 The block SHALL be a single module with no sub-modules; the memory stays external.

Verification
REQ-048 Bench SHALL cover: restart mid-LOAD -> state IDLE and all outputs 0 immediately, without waiting for a clka edge.
REQ-049 Bench SHALL cover: load_start with load_len=3 and bytes A9,01,00 -> 32 zero writes, then writes at 0,1,2, then cpu_run=1.
REQ-050 Bench SHALL cover: byte_valid toggling every other cycle during LOAD -> only valid cycles write, with addresses contiguous.
REQ-051 Bench SHALL cover: RUN fetches of pc 0,1,2 back-to-back -> acks on the three following cycles returning A9,01,00.
REQ-052 Bench SHALL cover: RUN fetch of pc=0x25 -> fetch_ack=1, fetch_inst=00 and pc_fault=1 one cycle later.
REQ-053 Bench SHALL cover: load_start with load_len=0 in RUN -> 32 clear cycles, then RUN, and fetch of pc 0 returns 00.

Source files
------------

// File: rtl/inst_pkg.sv
// inst_pkg: shared state encoding and constants for the instruction load controller
package inst_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_LOAD, ST_RUN} state_t;
    localparam int MEM_DEPTH_DEF = 32;
    localparam logic [7:0] FAULT_INST = 8'h00;
endpackage

// File: rtl/inst_load_ctrl.sv
// inst_load_ctrl: clears and loads an external instruction memory, then serves CPU fetches
module inst_load_ctrl
    import inst_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_W = 5
) (
    input  logic              clka,
    input  logic              restart,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    input  logic              fetch_req,
    input  logic [7:0]        fetch_pc,
    output logic              fetch_ack,
    output logic [7:0]        fetch_inst,
    output logic              pc_fault,
    output logic              cpu_run,
    output logic              load_busy
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(MEM_DEPTH-1);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
    state_t state_q, state_d;
    logic [ADDR_W:0] cnt_q, len_q;
    logic pend_q, fault_q;
    logic [7:0] hold_q;
    logic start, fetch, wr, last_clear, last_byte;
    assign start = (state_q == ST_IDLE || state_q == ST_RUN) && load_start;
    assign fetch = state_q == ST_RUN && fetch_req && !load_start;
    assign wr = state_q == ST_LOAD && byte_valid;
    assign last_clear = state_q == ST_CLEAR && cnt_q == LAST;
    assign last_byte = wr && cnt_q + ONE == len_q;
    always_ff @(posedge clka or posedge restart) begin
        if (restart) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        state_d = start ? ST_CLEAR
                : last_clear ? (len_q == '0 ? ST_RUN : ST_LOAD)
                : last_byte ? ST_RUN
                : state_q;
    end
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
            len_q <= load_len > DEPTH ? DEPTH : load_len;
        end else if (last_clear) begin
            cnt_q <= '0;
        end else if (state_q == ST_CLEAR || wr) begin
            cnt_q <= cnt_q + ONE;
        end
    end
    // fetch_inst is muxed straight from mem_rdata on the ack cycle and held afterwards
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            pend_q <= 1'b0;
            fault_q <= 1'b0;
            hold_q <= 8'h00;
        end else begin
            pend_q <= fetch;
            fault_q <= fetch && |(fetch_pc >> ADDR_W);
            if (pend_q) hold_q <= fetch_inst;
        end
    end
    assign byte_ready = state_q == ST_LOAD;
    assign mem_we = state_q == ST_CLEAR || wr;
    assign mem_waddr = cnt_q[ADDR_W-1:0];
    assign mem_wdata = wr ? byte_data : 8'h00;
    assign mem_raddr = state_q == ST_RUN ? fetch_pc[ADDR_W-1:0] : '0;
    assign fetch_ack = pend_q;
    assign pc_fault = pend_q && fault_q;
    assign fetch_inst = pend_q ? (fault_q ? FAULT_INST : mem_rdata) : hold_q;
    assign cpu_run = state_q == ST_RUN;
    assign load_busy = state_q == ST_CLEAR || state_q == ST_LOAD;
endmodule
